// File: rtl/demux_pkg.sv
// Shared encodings and statistics constants for the buffered 1:2 demultiplexer.
package demux_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  // Saturating increment for the per-channel accepted-word counters
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] cnt);
    return (cnt == STAT_MAX) ? cnt : cnt + STAT_W'(1);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO: circular storage with read/write pointers, an occupancy count
// and registered full/empty flags. The head word is read straight from storage.
module chan_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller forgets to qualify
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      mem_q    <= mem_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/demux1_2_buf.sv
// Buffered 1:2 demultiplexer: routes each input word to channel A or B by IN_SEL.
// Optional per-channel accepted-word counters are built when DEMUX_STATS_EN is defined.
module demux1_2_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  IN_DATA,
  input  logic              IN_SEL,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [WIDTH-1:0]  OUT_A_DATA,
  output logic              OUT_A_VALID,
  input  logic              OUT_A_READY,
  output logic [WIDTH-1:0]  OUT_B_DATA,
  output logic              OUT_B_VALID,
  input  logic              OUT_B_READY
`ifdef DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] COUNT_A,
  output logic [STAT_W-1:0] COUNT_B
`endif
);

  logic sel_b;
  logic push_a, push_b;
  logic pop_a, pop_b;
  logic full_a, full_b;
  logic empty_a, empty_b;

  // Ready depends only on the select and the registered full flags
  always_comb begin
    sel_b    = (IN_SEL == CH_B);
    IN_READY = sel_b ? !full_b : !full_a;
    push_a   = IN_VALID && IN_READY && !sel_b;
    push_b   = IN_VALID && IN_READY && sel_b;
    pop_a    = OUT_A_READY && !empty_a;
    pop_b    = OUT_B_READY && !empty_b;
  end

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_a),
    .push_data (IN_DATA),
    .pop       (pop_a),
    .full      (full_a),
    .empty     (empty_a),
    .head      (OUT_A_DATA)
  );

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_b),
    .push_data (IN_DATA),
    .pop       (pop_b),
    .full      (full_b),
    .empty     (empty_b),
    .head      (OUT_B_DATA)
  );

  assign OUT_A_VALID = !empty_a;
  assign OUT_B_VALID = !empty_b;

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] cnt_a_q, cnt_a_d;
  logic [STAT_W-1:0] cnt_b_q, cnt_b_d;

  // Saturating counters of accepted pushes per channel
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (push_a) cnt_a_d = stat_inc(cnt_a_q);
    if (push_b) cnt_b_d = stat_inc(cnt_b_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign COUNT_A = cnt_a_q;
  assign COUNT_B = cnt_b_q;
`endif

endmodule
